// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_sequencer
//  Brief    : Command-buffer sequencer. Runs register writes, strobes,
//             interrupt waits/clears, jumps and counted loops from an
//             internal instruction RAM. Optional wait timeout is enabled by
//             defining CMD_SEQ_WAIT_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cmd_sequencer #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int NINT       = 32,
    parameter int NSTB       = 32,
    parameter int CNT_W      = 16,
    parameter int WAIT_TO    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ext_buffer_addr,
    input  logic [DATA_W+7:0]     ext_buffer_data,
    input  logic                  ext_buffer_wr,
    output logic [REG_ADDR_W-1:0] ext_out_reg_addr,
    output logic [DATA_W-1:0]     ext_out_reg_data,
    output logic                  ext_out_reg_stb,
    input  logic                  ext_out_reg_busy,
    output logic [NSTB-1:0]       ext_out_stbs,
    input  logic [NINT-1:0]       ext_pending_ints,
    output logic [NINT-1:0]       ext_clear_ints,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic                  abort,
    output logic                  complete,
    output logic [ADDR_W-1:0]     pc,
    output logic [7:0]            error,
    output logic                  busy,
    output logic                  waiting
);

    localparam int IW = DATA_W + 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       pc_q, pc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    waiting_q, waiting_d;
    logic                    cmpl_q, cmpl_d;
    logic                    reg_stb_q, reg_stb_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]       reg_data_q, reg_data_d;
    logic [NSTB-1:0]         stbs_q, stbs_d;
    logic [NINT-1:0]         clr_q, clr_d;
    logic [IW-1:0]           instr_q;
    logic [IW-1:0]           mem [2**ADDR_W];

    logic [1:0]              w_class;
    logic [5:0]              w_op;
    logic [DATA_W-1:0]       w_p;
    logic [DATA_W-1:0]       w_ints;
    logic                    w_wait_met;
    logic [ADDR_W-1:0]       w_pc_inc;

`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
    localparam int WCNT_W = $clog2(WAIT_TO + 1);
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
`endif

    // Synchronous-read RAM: a loader write and a fetch of the same word in
    // one cycle return the previous contents.
    always_ff @(posedge clk) begin
        if (ext_buffer_wr) begin
            mem[ext_buffer_addr] <= ext_buffer_data;
        end
        if (state_q == S_FETCH) begin
            instr_q <= mem[pc_q];
        end
    end

    assign w_class    = instr_q[IW-1:IW-2];
    assign w_op       = instr_q[IW-3:DATA_W];
    assign w_p        = instr_q[DATA_W-1:0];
    assign w_ints     = DATA_W'(ext_pending_ints);
    assign w_wait_met = (w_op == 6'd2) ? ((w_ints & w_p) == w_p) : (|(w_ints & w_p));
    assign w_pc_inc   = pc_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        busy_d     = busy_q;
        waiting_d  = 1'b0;
        cmpl_d     = 1'b0;
        reg_stb_d  = 1'b0;
        reg_addr_d = '0;
        reg_data_d = '0;
        stbs_d     = '0;
        clr_d      = '0;
`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
        wcnt_d     = wcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = start_addr;
                    err_d   = 8'h00;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            S_DECODE: begin
                state_d = S_FETCH;
                pc_d    = w_pc_inc;
                if (w_class == 2'b01) begin
                    if (ext_out_reg_busy) begin
                        state_d = S_DECODE;
                        pc_d    = pc_q;
                    end else begin
                        reg_stb_d  = 1'b1;
                        reg_addr_d = instr_q[DATA_W +: REG_ADDR_W];
                        reg_data_d = w_p;
                    end
                end else if (w_class == 2'b10) begin
                    case (w_op)
                        6'd0: ;
                        6'd1: stbs_d = w_p[NSTB-1:0];
                        6'd2, 6'd3: begin
                            if (!w_wait_met) begin
                                state_d = S_DECODE;
                                pc_d    = pc_q;
`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
                                if (wcnt_q == WCNT_W'(WAIT_TO - 1)) begin
                                    state_d = S_IDLE;
                                    busy_d  = 1'b0;
                                    cmpl_d  = 1'b1;
                                    err_d   = 8'h83;
                                end else begin
                                    wcnt_d    = wcnt_q + WCNT_W'(1);
                                    waiting_d = 1'b1;
                                end
`else
                                waiting_d = 1'b1;
`endif
                            end
                        end
                        6'd4: clr_d = w_p[NINT-1:0];
                        6'd5: pc_d  = w_p[ADDR_W-1:0];
                        6'd6: cnt_d = w_p[CNT_W-1:0];
                        6'd7: begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - CNT_W'(1);
                                pc_d  = w_p[ADDR_W-1:0];
                            end
                        end
                        6'd63: begin
                            state_d = S_IDLE;
                            pc_d    = pc_q;
                            busy_d  = 1'b0;
                            cmpl_d  = 1'b1;
                            err_d   = w_p[7:0];
                        end
                        default: begin
                            state_d = S_IDLE;
                            pc_d    = pc_q;
                            busy_d  = 1'b0;
                            cmpl_d  = 1'b1;
                            err_d   = 8'h81;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                    pc_d    = pc_q;
                    busy_d  = 1'b0;
                    cmpl_d  = 1'b1;
                    err_d   = 8'h81;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything decided above, including a pending write.
        if (abort) begin
            state_d    = S_IDLE;
            pc_d       = '0;
            err_d      = 8'h82;
            busy_d     = 1'b0;
            waiting_d  = 1'b0;
            cmpl_d     = 1'b0;
            reg_stb_d  = 1'b0;
            reg_addr_d = '0;
            reg_data_d = '0;
            stbs_d     = '0;
            clr_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            waiting_q  <= 1'b0;
            cmpl_q     <= 1'b0;
            reg_stb_q  <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            stbs_q     <= '0;
            clr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            waiting_q  <= waiting_d;
            cmpl_q     <= cmpl_d;
            reg_stb_q  <= reg_stb_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            stbs_q     <= stbs_d;
            clr_q      <= clr_d;
        end
    end

`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

    assign ext_out_reg_addr = reg_addr_q;
    assign ext_out_reg_data = reg_data_q;
    assign ext_out_reg_stb  = reg_stb_q;
    assign ext_out_stbs     = stbs_q;
    assign ext_clear_ints   = clr_q;
    assign complete         = cmpl_q;
    assign pc               = pc_q;
    assign error            = err_q;
    assign busy             = busy_q;
    assign waiting          = waiting_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_sequencer
//  Brief    : Directed self-checking bench for cmd_sequencer (default sizes,
//             WAIT_TO=8 so the optional CMD_SEQ_WAIT_TIMEOUT_EN build is short).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] ext_buffer_addr = '0;
    logic [39:0] ext_buffer_data = '0;
    logic        ext_buffer_wr = 1'b0;
    logic [5:0]  ext_out_reg_addr;
    logic [31:0] ext_out_reg_data;
    logic        ext_out_reg_stb;
    logic        ext_out_reg_busy = 1'b0;
    logic [31:0] ext_out_stbs;
    logic [31:0] ext_pending_ints = '0;
    logic [31:0] ext_clear_ints;
    logic        start = 1'b0;
    logic [12:0] start_addr = '0;
    logic        abort = 1'b0;
    logic        complete;
    logic [12:0] pc;
    logic [7:0]  error;
    logic        busy;
    logic        waiting;

    int checks = 0;
    int errors = 0;

    int          stb_cnt, idle_bad, stbs_cnt, clr_cnt, cmpl_cnt;
    logic [5:0]  last_addr;
    logic [31:0] last_data, last_stbs, last_clr;

    cmd_sequencer #(.WAIT_TO(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .ext_buffer_addr  (ext_buffer_addr),
        .ext_buffer_data  (ext_buffer_data),
        .ext_buffer_wr    (ext_buffer_wr),
        .ext_out_reg_addr (ext_out_reg_addr),
        .ext_out_reg_data (ext_out_reg_data),
        .ext_out_reg_stb  (ext_out_reg_stb),
        .ext_out_reg_busy (ext_out_reg_busy),
        .ext_out_stbs     (ext_out_stbs),
        .ext_pending_ints (ext_pending_ints),
        .ext_clear_ints   (ext_clear_ints),
        .start            (start),
        .start_addr       (start_addr),
        .abort            (abort),
        .complete         (complete),
        .pc               (pc),
        .error            (error),
        .busy             (busy),
        .waiting          (waiting)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ext_out_reg_stb) begin
            stb_cnt   = stb_cnt + 1;
            last_addr = ext_out_reg_addr;
            last_data = ext_out_reg_data;
        end else if (ext_out_reg_addr != '0 || ext_out_reg_data != '0) begin
            idle_bad = idle_bad + 1;
        end
        if (ext_out_stbs != '0) begin
            stbs_cnt  = stbs_cnt + 1;
            last_stbs = ext_out_stbs;
        end
        if (ext_clear_ints != '0) begin
            clr_cnt  = clr_cnt + 1;
            last_clr = ext_clear_ints;
        end
        if (complete) cmpl_cnt = cmpl_cnt + 1;
    end

    function automatic logic [39:0] f_wr(input logic [5:0] r, input logic [31:0] d);
        return {2'b01, r, d};
    endfunction

    function automatic logic [39:0] f_op(input logic [5:0] o, input logic [31:0] p);
        return {2'b10, o, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [12:0] a, input logic [39:0] d);
        ext_buffer_addr = a;
        ext_buffer_data = d;
        ext_buffer_wr   = 1'b1;
        tick();
        ext_buffer_wr   = 1'b0;
    endtask

    task automatic clr_mon();
        stb_cnt = 0; idle_bad = 0; stbs_cnt = 0; clr_cnt = 0; cmpl_cnt = 0;
        last_addr = '0; last_data = '0; last_stbs = '0; last_clr = '0;
    endtask

    task automatic do_start(input logic [12:0] a);
        clr_mon();
        start_addr = a;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (!complete && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (!complete) begin
            errors++;
            $display("FAIL done_timeout: complete=%0b after %0d cycles, required 1", complete, n);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, complete, waiting, ext_out_reg_stb} !== 4'b0 || pc !== '0 || error !== '0 ||
            ext_out_stbs !== '0 || ext_clear_ints !== '0 || ext_out_reg_addr !== '0 ||
            ext_out_reg_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b cmpl=%0b pc=%0h err=%0h, required all 0", busy, complete, pc, error);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_reg();
        int n;
        load(13'h0, f_wr(6'd5, 32'hDEADBEEF));
        load(13'h1, f_op(6'd63, 32'h0));
        do_start(13'h0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy_after_start: busy=%0b required 1", busy);
        end
        wait_done(50, n);
        checks++;
        if (stb_cnt != 1 || last_addr !== 6'd5 || last_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_stb: count=%0d addr=%0h data=%0h, required 1/5/deadbeef", stb_cnt, last_addr, last_data);
        end
        checks++;
        if (error !== 8'h00 || busy !== 1'b0 || cmpl_cnt != 1 || idle_bad != 0) begin
            errors++;
            $display("FAIL wr_done: err=%0h busy=%0b cmpl=%0d idle_bad=%0d, required 0/0/1/0", error, busy, cmpl_cnt, idle_bad);
        end
    endtask

    task automatic test_bus_busy();
        int n;
        load(13'h8, f_wr(6'd3, 32'h12345678));
        load(13'h9, f_op(6'd63, 32'h0));
        ext_out_reg_busy = 1'b1;
        do_start(13'h8);
        repeat (10) tick();
        checks++;
        if (stb_cnt != 0 || pc !== 13'h8) begin
            errors++;
            $display("FAIL busy_stall: stbs=%0d pc=%0h, required 0/8", stb_cnt, pc);
        end
        ext_out_reg_busy = 1'b0;
        tick();
        checks++;
        if (ext_out_reg_stb !== 1'b1 || ext_out_reg_addr !== 6'd3 || ext_out_reg_data !== 32'h12345678 || pc !== 13'h9) begin
            errors++;
            $display("FAIL busy_release: stb=%0b addr=%0h data=%0h pc=%0h, required 1/3/12345678/9",
                     ext_out_reg_stb, ext_out_reg_addr, ext_out_reg_data, pc);
        end
        wait_done(50, n);
        checks++;
        if (stb_cnt != 1 || error !== 8'h00) begin
            errors++;
            $display("FAIL busy_single_stb: count=%0d err=%0h, required 1/0", stb_cnt, error);
        end
    endtask

    task automatic test_loop();
        int n;
        load(13'h10, f_op(6'd6, 32'd3));
        load(13'h11, f_op(6'd1, 32'h1));
        load(13'h12, f_op(6'd7, 32'h11));
        load(13'h13, f_op(6'd63, 32'h7));
        do_start(13'h10);
        wait_done(200, n);
        checks++;
        if (stbs_cnt != 4 || last_stbs !== 32'h1) begin
            errors++;
            $display("FAIL loop_stbs: pulses=%0d value=%0h, required 4/1", stbs_cnt, last_stbs);
        end
        checks++;
        if (error !== 8'h07 || pc !== 13'h13) begin
            errors++;
            $display("FAIL loop_done: err=%0h pc=%0h, required 07/13", error, pc);
        end
    endtask

    task automatic test_wait_all();
        int n;
        load(13'h20, f_op(6'd2, 32'h3));
        load(13'h21, f_op(6'd63, 32'h5));
        ext_pending_ints = 32'h1;
        do_start(13'h20);
        repeat (20) tick();
        checks++;
        if (waiting !== 1'b1 || pc !== 13'h20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall: waiting=%0b pc=%0h busy=%0b, required 1/20/1", waiting, pc, busy);
        end
        ext_pending_ints = 32'h3;
        wait_done(20, n);
        checks++;
        if (error !== 8'h05 || waiting !== 1'b0) begin
            errors++;
            $display("FAIL wait_release: err=%0h waiting=%0b, required 05/0", error, waiting);
        end
        ext_pending_ints = '0;
    endtask

    task automatic test_jump_clear();
        int n;
        load(13'h40, f_op(6'd5, 32'h50));
        load(13'h50, f_op(6'd4, 32'hA5));
        load(13'h51, f_op(6'd63, 32'h11));
        do_start(13'h40);
        wait_done(50, n);
        checks++;
        if (clr_cnt != 1 || last_clr !== 32'hA5 || error !== 8'h11 || pc !== 13'h51) begin
            errors++;
            $display("FAIL jump_clear: clr=%0d val=%0h err=%0h pc=%0h, required 1/a5/11/51", clr_cnt, last_clr, error, pc);
        end
    endtask

    task automatic test_fault();
        int n;
        load(13'h60, {2'b00, 6'd0, 32'h0});
        load(13'h61, f_op(6'd9, 32'h0));
        do_start(13'h60);
        wait_done(50, n);
        checks++;
        if (error !== 8'h81 || pc !== 13'h60) begin
            errors++;
            $display("FAIL fault_class: err=%0h pc=%0h, required 81/60", error, pc);
        end
        do_start(13'h61);
        wait_done(50, n);
        checks++;
        if (error !== 8'h81 || pc !== 13'h61) begin
            errors++;
            $display("FAIL fault_op: err=%0h pc=%0h, required 81/61", error, pc);
        end
    endtask

    task automatic test_abort();
        load(13'h30, f_op(6'd3, 32'h4));
        ext_pending_ints = '0;
        do_start(13'h30);
        repeat (5) tick();
        checks++;
        if (waiting !== 1'b1) begin
            errors++;
            $display("FAIL abort_prewait: waiting=%0b required 1", waiting);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || waiting !== 1'b0 || pc !== '0 || error !== 8'h82 || complete !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%0b wait=%0b pc=%0h err=%0h cmpl=%0b, required 0/0/0/82/0",
                     busy, waiting, pc, error, complete);
        end
        repeat (3) tick();
        checks++;
        if (cmpl_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_complete: cmpl=%0d busy=%0b, required 0/0", cmpl_cnt, busy);
        end
    endtask

    task automatic test_rst_mid();
        do_start(13'h10);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, complete, waiting, ext_out_reg_stb} !== 4'b0 || pc !== '0 || error !== '0 ||
            ext_out_stbs !== '0 || ext_clear_ints !== '0) begin
            errors++;
            $display("FAIL rst_mid: busy=%0b pc=%0h err=%0h stbs=%0h, required all 0", busy, pc, error, ext_out_stbs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int n;
        load(13'h1FFF, f_op(6'd0, 32'h0));
        load(13'h0, f_op(6'd63, 32'h22));
        do_start(13'h1FFF);
        wait_done(50, n);
        checks++;
        if (error !== 8'h22 || pc !== 13'h0) begin
            errors++;
            $display("FAIL pc_wrap: err=%0h pc=%0h, required 22/0", error, pc);
        end
    endtask

`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        load(13'h70, f_op(6'd3, 32'h8));
        ext_pending_ints = '0;
        do_start(13'h70);
        wait_done(50, n);
        checks++;
        if (error !== 8'h83 || n != 9 || cmpl_cnt != 1) begin
            errors++;
            $display("FAIL wait_timeout: err=%0h cycles=%0d cmpl=%0d, required 83/9/1", error, n, cmpl_cnt);
        end
    endtask
`endif

    initial begin
        clr_mon();
        test_reset();
        test_write_reg();
        test_bus_busy();
        test_loop();
        test_wait_all();
        test_jump_clear();
        test_fault();
        test_abort();
        test_rst_mid();
        test_wrap();
`ifdef CMD_SEQ_WAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
